// File: rtl/citadel_bus_pkg.sv
// citadel_bus_pkg
// Shared definitions for the CPU/DMA bus arbiter and the SRAM/IO decode slave.
// It holds the arbiter state encoding, the bus widths, the default error read
// data returned on a watchdog timeout, and the address map constants.
package citadel_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   // Width of the saturating timeout event counter.
   localparam int            TCNT_W   = 8;
   localparam logic [TCNT_W-1:0] TCNT_MAX = '1;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // Address map shared with the decode slave.
   localparam logic [ADDR_W-1:0] SRAM_BASE  = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] SRAM_LIMIT = 32'h0000_FFFF;
   localparam logic [ADDR_W-1:0] IO_BASE    = 32'h0100_0000;
   localparam logic [ADDR_W-1:0] IO_UART    = 32'h0100_0000;
   localparam logic [ADDR_W-1:0] IO_GPIO    = 32'h0100_0004;
   localparam logic [ADDR_W-1:0] IO_TIMER   = 32'h0100_0008;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when an address falls in the IO window (top byte 0x01).
   function automatic logic is_io(input logic [ADDR_W-1:0] addr);
      return (addr[ADDR_W-1:24] == IO_BASE[ADDR_W-1:24]);
   endfunction

endpackage

// File: rtl/citadel_bus_if.sv
// citadel_bus_if
// One valid/ready native bus link. The requester drives valid, addr, wdata
// and wstrb (wstrb == 0 means read); the responder drives ready (single-cycle
// completion pulse) and rdata (valid while ready is high).
//   modport master : requester side
//   modport slave  : responder side
interface citadel_bus_if;
   import citadel_bus_pkg::*;

   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/citadel_bus_timer.sv
// citadel_bus_timer
// Bus watchdog. Counts enabled cycles since the last clear and flags expiry in
// the TIMEOUT_CYCLES-th enabled cycle (first enabled cycle after a clear is
// cycle 1). TIMEOUT_CYCLES = 0 disables expiry.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the count (held while the bus is not busy)
//   en       : count this cycle
//   expire   : combinational, high in the expiring cycle
module citadel_bus_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // Count value seen during the expiring cycle (count starts at 0 in cycle 1).
   localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic ENABLED = (TIMEOUT_CYCLES > 0);

   logic [CNT_W-1:0] cnt_q;

   assign expire = ENABLED && en && (cnt_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !expire) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/citadel_bus_arbiter.sv
// citadel_bus_arbiter
// Shares one valid/ready memory/IO bus between the CPU (m0) and a second
// requester such as a boot loader or DMA engine (m1), one transfer at a time.
// A transfer runs IDLE -> BUSY -> DONE; DONE drops s.valid for one cycle so the
// slave can clear its ready. Ties are broken toward the master not served
// last. A watchdog forces completion with ERR_RDATA if the slave hangs.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   m0, m1      : master links (arbiter is the responder)
//   s           : slave link (arbiter is the requester)
//   timeout_err : one-cycle pulse on a forced completion
//   timeout_cnt : saturating count of forced completions
module citadel_bus_arbiter
   import citadel_bus_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   citadel_bus_if.slave       m0,
   citadel_bus_if.slave       m1,
   citadel_bus_if.master      s,
   output logic               timeout_err,
   output logic [TCNT_W-1:0]  timeout_cnt
);

   state_t            state_q, state_d;
   logic              grant_q, grant_d;            // 0 = m0, 1 = m1
   logic              last_grant_q, last_grant_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;

   logic              wd_expire;
   logic              xfer_done;
   logic [DATA_W-1:0] xfer_rdata;

   assign timeout_cnt = tcnt_q;

   // Watchdog is held clear outside BUSY, so it restarts on every BUSY entry.
   citadel_bus_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_q != BUSY),
      .en     (state_q == BUSY),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         tcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tcnt_q       <= tcnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tcnt_d       = tcnt_q;
      xfer_done    = 1'b0;
      xfer_rdata   = '0;
      timeout_err  = 1'b0;
      s.valid      = 1'b0;
      s.addr       = '0;
      s.wdata      = '0;
      s.wstrb      = '0;
      m0.ready     = 1'b0;
      m0.rdata     = '0;
      m1.ready     = 1'b0;
      m1.rdata     = '0;

      case (state_q)
         IDLE: begin
            if (m0.valid && m1.valid) begin
               grant_d = ~last_grant_q;
               state_d = BUSY;
            end else if (m0.valid) begin
               grant_d = 1'b0;
               state_d = BUSY;
            end else if (m1.valid) begin
               grant_d = 1'b1;
               state_d = BUSY;
            end
         end

         BUSY: begin
            s.valid = 1'b1;
            if (grant_q) begin
               s.addr  = m1.addr;
               s.wdata = m1.wdata;
               s.wstrb = m1.wstrb;
            end else begin
               s.addr  = m0.addr;
               s.wdata = m0.wdata;
               s.wstrb = m0.wstrb;
            end

            // A real slave response in the expiry cycle takes precedence.
            if (s.ready) begin
               xfer_done  = 1'b1;
               xfer_rdata = s.rdata;
            end else if (wd_expire) begin
               xfer_done   = 1'b1;
               xfer_rdata  = ERR_RDATA;
               timeout_err = 1'b1;
               if (tcnt_q != TCNT_MAX) begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end

            if (xfer_done) begin
               // Forced completions count as service for fairness too.
               last_grant_d = grant_q;
               state_d      = DONE;
            end

            m0.ready = xfer_done && !grant_q;
            m1.ready = xfer_done &&  grant_q;
            m0.rdata = (xfer_done && !grant_q) ? xfer_rdata : '0;
            m1.rdata = (xfer_done &&  grant_q) ? xfer_rdata : '0;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_citadel_bus_arbiter.sv
// tb_citadel_bus_arbiter
// Self-checking bench for citadel_bus_arbiter with an 8-cycle watchdog.
// Directed per-cycle vector table, hand-written timeout / reset sequences,
// and a randomized run against a transaction-level timing model.
module tb_citadel_bus_arbiter;
   import citadel_bus_pkg::*;

   localparam int TO = 8;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] D0 = 32'h0000_0000;
   localparam logic [3:0]  S0 = 4'b0000;
   localparam logic [31:0] A1 = 32'h0100_0004;
   localparam logic [31:0] D1 = 32'h0000_0042;
   localparam logic [3:0]  S1 = 4'b0001;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   typedef logic [143:0] obs_t;

   typedef struct {
      logic        m0v;
      logic        m1v;
      logic        sr;
      logic [31:0] srd;
      logic        esv;
      logic        eg;
      logic        er0;
      logic        er1;
      logic [31:0] erd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       timeout_err;
   logic [7:0] timeout_cnt;

   always #5 clk = ~clk;

   citadel_bus_if m0_bus ();
   citadel_bus_if m1_bus ();
   citadel_bus_if s_bus ();

   citadel_bus_arbiter #(
      .TIMEOUT_CYCLES (TO),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_bus),
      .m1          (m1_bus),
      .s           (s_bus),
      .timeout_err (timeout_err),
      .timeout_cnt (timeout_cnt)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] tcnt_m;
   vec_t       tbl[$];

   // random-run model state
   int          idle_from, comp, bstart, win, lat;
   int          done_cyc[2];
   logic        last_w;
   logic        pend[2];
   logic [31:0] ra[2], rw[2];
   logic [3:0]  rs[2];
   logic [31:0] rdv;

   function automatic vec_t row(input logic m0v, m1v, sr, input logic [31:0] srd,
                                input logic esv, eg, er0, er1, input logic [31:0] erd);
      vec_t v;
      v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
      v.esv = esv; v.eg = eg; v.er0 = er0; v.er1 = er1; v.erd = erd;
      return v;
   endfunction

   function automatic obs_t obs();
      return {s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb,
              m0_bus.ready, m0_bus.rdata, m1_bus.ready, m1_bus.rdata,
              timeout_err, timeout_cnt};
   endfunction

   function automatic obs_t mk(input logic sv, input logic [31:0] a, d, input logic [3:0] st,
                               input logic r0, input logic [31:0] d0,
                               input logic r1, input logic [31:0] d1,
                               input logic err, input logic [7:0] cnt);
      return {sv, a, d, st, r0, d0, r1, d1, err, cnt};
   endfunction

   function automatic obs_t quiet(input logic [7:0] cnt);
      return mk(F, 32'h0, 32'h0, 4'h0, F, 32'h0, F, 32'h0, F, cnt);
   endfunction

   task automatic set_m0(input logic v, input logic [31:0] a, d, input logic [3:0] st);
      m0_bus.valid = v; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wstrb = st;
   endtask

   task automatic set_m1(input logic v, input logic [31:0] a, d, input logic [3:0] st);
      m1_bus.valid = v; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wstrb = st;
   endtask

   task automatic chk_now(input string nm, input obs_t e);
      obs_t g;
      g = obs();
      n_cmp++;
      if (g !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, g, e);
      end
   endtask

   // Called at posedge+1 with inputs set; checks mid-cycle, returns at next posedge+1.
   task automatic cyc_check(input string nm, input obs_t e);
      @(negedge clk);
      chk_now(nm, e);
      @(posedge clk);
      #1;
   endtask

   // m0 read of A0; slave answers in BUSY cycle rdy_at (0 = never).
   task automatic txn0(input string nm, input int rdy_at, input logic [31:0] rd);
      logic done, to;
      set_m0(T, A0, D0, S0);
      set_m1(F, A1, D1, S1);
      s_bus.ready = F;
      s_bus.rdata = 32'h0;
      cyc_check({nm, " idle"}, quiet(tcnt_m));
      for (int k = 1; k <= TO; k++) begin
         s_bus.ready = (k == rdy_at);
         s_bus.rdata = (k == rdy_at) ? rd : $urandom;
         done = (k == rdy_at) || (k == TO);
         to   = done && (k != rdy_at);
         cyc_check($sformatf("%s busy%0d", nm, k),
                   mk(T, A0, D0, S0, done, done ? (to ? ERRD : rd) : 32'h0,
                      F, 32'h0, to, tcnt_m));
         if (to && tcnt_m != 8'hFF) tcnt_m++;
         if (done) break;
      end
      set_m0(F, A0, D0, S0);
      s_bus.ready = F;
      cyc_check({nm, " done"}, quiet(tcnt_m));
   endtask

   task automatic run_random(input int ncyc);
      logic        in_busy, done, to;
      logic [31:0] ea, ed, erd;
      logic [3:0]  es;
      int          k;
      idle_from = 0; comp = -10; bstart = -10; win = 2; lat = 1;
      last_w = T; tcnt_m = 8'h0; rdv = 32'h0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = F; done_cyc[i] = -10;
         ra[i] = 32'h0; rw[i] = 32'h0; rs[i] = 4'h0;
      end
      for (int t = 0; t < ncyc; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && win == i && t == comp + 1) begin
               pend[i] = F;
               done_cyc[i] = t;
            end else if (!pend[i] && t != done_cyc[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = T;
               ra[i] = $urandom;
               rw[i] = $urandom;
               rs[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
         end
         set_m0(pend[0], ra[0], rw[0], rs[0]);
         set_m1(pend[1], ra[1], rw[1], rs[1]);

         // Arbitration happens in any cycle the bus is idle and someone asks.
         if (t >= idle_from && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) win = last_w ? 0 : 1;
            else                    win = pend[1] ? 1 : 0;
            last_w    = (win == 1);
            lat       = $urandom_range(1, TO + 3);
            bstart    = t + 1;
            comp      = t + ((lat < TO) ? lat : TO);
            idle_from = comp + 2;
            rdv       = $urandom;
         end

         in_busy = (t >= bstart) && (t <= comp);
         if (in_busy) begin
            k = t - bstart + 1;
            s_bus.ready = (k == lat);
            s_bus.rdata = (k == lat) ? rdv : $urandom;
         end else begin
            s_bus.ready = ($urandom_range(0, 3) == 0);
            s_bus.rdata = $urandom;
         end

         done = in_busy && (t == comp);
         to   = done && (lat > TO);
         erd  = to ? ERRD : rdv;
         ea   = in_busy ? ((win == 1) ? ra[1] : ra[0]) : 32'h0;
         ed   = in_busy ? ((win == 1) ? rw[1] : rw[0]) : 32'h0;
         es   = in_busy ? ((win == 1) ? rs[1] : rs[0]) : 4'h0;
         cyc_check($sformatf("rand t=%0d", t),
                   mk(in_busy, ea, ed, es,
                      done && win == 0, (done && win == 0) ? erd : 32'h0,
                      done && win == 1, (done && win == 1) ? erd : 32'h0,
                      to, tcnt_m));
         if (to && tcnt_m != 8'hFF) tcnt_m++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // tie / alternation, lone m0 read, m1 write
      tbl.push_back(row(T, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, T, 32'h1111_0001, T, F, T, F, 32'h1111_0001));
      tbl.push_back(row(F, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, T, 32'h2222_0002, T, T, F, T, 32'h2222_0002));
      tbl.push_back(row(T, F, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, T, 32'h3333_0003, T, F, T, F, 32'h3333_0003));
      tbl.push_back(row(F, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, T, T, 32'h4444_0004, T, T, F, T, 32'h4444_0004));
      tbl.push_back(row(F, F, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(F, F, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, F, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(T, F, F, 32'h5555_5555, T, F, F, F, 32'h0));
      tbl.push_back(row(T, F, T, 32'h1234_5678, T, F, T, F, 32'h1234_5678));
      tbl.push_back(row(F, F, T, 32'h9999_9999, F, F, F, F, 32'h0));
      tbl.push_back(row(F, F, T, 32'h9999_9999, F, F, F, F, 32'h0));
      tbl.push_back(row(F, T, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(F, T, F, 32'h0,         T, T, F, F, 32'h0));
      tbl.push_back(row(F, T, T, 32'hAAAA_5555, T, T, F, T, 32'hAAAA_5555));
      tbl.push_back(row(F, F, F, 32'h0,         F, F, F, F, 32'h0));
      tbl.push_back(row(F, F, F, 32'h0,         F, F, F, F, 32'h0));

      set_m0(F, 32'h0, 32'h0, 4'h0);
      set_m1(F, 32'h0, 32'h0, 4'h0);
      s_bus.ready = F;
      s_bus.rdata = 32'h0;
      rst = T;
      tcnt_m = 8'h0;
      @(posedge clk);
      #1;
      cyc_check("reset state", quiet(8'h0));
      rst = F;

      for (int i = 0; i < tbl.size(); i++) begin
         set_m0(tbl[i].m0v, A0, D0, S0);
         set_m1(tbl[i].m1v, A1, D1, S1);
         s_bus.ready = tbl[i].sr;
         s_bus.rdata = tbl[i].srd;
         cyc_check($sformatf("vec%0d", i),
                   mk(tbl[i].esv,
                      tbl[i].esv ? (tbl[i].eg ? A1 : A0) : 32'h0,
                      tbl[i].esv ? (tbl[i].eg ? D1 : D0) : 32'h0,
                      tbl[i].esv ? (tbl[i].eg ? S1 : S0) : 4'h0,
                      tbl[i].er0, tbl[i].er0 ? tbl[i].erd : 32'h0,
                      tbl[i].er1, tbl[i].er1 ? tbl[i].erd : 32'h0,
                      F, 8'h0));
      end

      // watchdog: forced completion, same-cycle race, early answer, saturation
      txn0("timeout", 0, 32'h0);
      txn0("race", TO, 32'hC0DE_0008);
      txn0("early", 3, 32'h0ACE_0003);
      for (int r = 0; r < 300; r++) txn0("sat", 0, 32'h0);
      n_cmp++;
      if (timeout_cnt !== 8'd255) begin
         n_bad++;
         $display("FAIL saturated count: got %0d expected 255", timeout_cnt);
      end

      // reset in the middle of an m1 transfer, after m0 was served last
      txn0("pre", 1, 32'h0BAD_F00D);
      set_m1(T, A1, D1, S1);
      cyc_check("rstseq idle", quiet(tcnt_m));
      cyc_check("rstseq busy1", mk(T, A1, D1, S1, F, 32'h0, F, 32'h0, F, tcnt_m));
      s_bus.ready = T;
      s_bus.rdata = 32'h7777_7777;
      rst = T;
      #2;
      chk_now("rst async", quiet(8'h0));
      @(posedge clk);
      #1;
      rst = F;
      tcnt_m = 8'h0;
      s_bus.ready = F;
      set_m0(T, A0, D0, S0);
      cyc_check("post idle", quiet(8'h0));
      s_bus.ready = T;
      s_bus.rdata = 32'h5151_0000;
      cyc_check("post tie m0", mk(T, A0, D0, S0, T, 32'h5151_0000, F, 32'h0, F, 8'h0));
      set_m0(F, A0, D0, S0);
      s_bus.ready = F;
      cyc_check("post done", quiet(8'h0));
      cyc_check("post idle2", quiet(8'h0));
      s_bus.ready = T;
      s_bus.rdata = 32'h5252_0000;
      cyc_check("post m1", mk(T, A1, D1, S1, F, 32'h0, T, 32'h5252_0000, F, 8'h0));
      set_m1(F, A1, D1, S1);
      s_bus.ready = F;
      cyc_check("post done2", quiet(8'h0));

      // randomized run from a fresh reset
      rst = T;
      set_m0(F, 32'h0, 32'h0, 4'h0);
      set_m1(F, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      rst = F;
      run_random(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
